// File: rtl/jk_pkg.sv
// Shared JK excitation encoding ({J,K}) and default counter geometry.
package jk_pkg;

  localparam int unsigned JK_DEF_WIDTH = 4;
  localparam int unsigned JK_DEF_MOD   = 10;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_exc_e;

  // Excitation that drives a cell to a known value regardless of its state.
  function automatic jk_exc_e jk_force(input logic b);
    return b ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      case (jk_exc_e'({j, k}))
        JK_HOLD:   q_q <= q_q;
        JK_RESET:  q_q <= 1'b0;
        JK_SET:    q_q <= 1'b1;
        JK_TOGGLE: q_q <= ~q_q;
        default:   q_q <= q_q;
      endcase
    end
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: rtl/jk_counter.sv
// Modulo-MOD up/down counter built from WIDTH JK cells with combinational excitation.
// Define JK_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module jk_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = JK_DEF_WIDTH,
  parameter int unsigned MOD   = JK_DEF_MOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             load_err
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] j_d, k_d;
  logic [WIDTH-1:0] load_tgt;
  logic             load_oob;
  logic             at_max, at_zero;
  logic             ripple;
  logic             tc_d, tc_q;
  logic             lerr_d, lerr_q;

  assign load_oob = ({1'b0, load_val} >= MOD_W);
  assign load_tgt = load_oob ? MAX_V : load_val;
  assign at_max   = (count == MAX_V);
  assign at_zero  = (count == '0);

  // ripple tracks "all lower bits are 1 (up) / 0 (down)" while walking the cells.
  always_comb begin
    j_d    = '0;
    k_d    = '0;
    tc_d   = 1'b0;
    lerr_d = 1'b0;
    ripple = 1'b1;
    if (load) begin
      lerr_d = load_oob;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        {j_d[i], k_d[i]} = jk_force(load_tgt[i]);
      end
    end else if (en) begin
      if (up && at_max) begin
        tc_d = 1'b1;
`ifndef JK_COUNTER_SAT_EN
        for (int unsigned i = 0; i < WIDTH; i++) begin
          {j_d[i], k_d[i]} = JK_RESET;
        end
`endif
      end else if (!up && at_zero) begin
        tc_d = 1'b1;
`ifndef JK_COUNTER_SAT_EN
        for (int unsigned i = 0; i < WIDTH; i++) begin
          {j_d[i], k_d[i]} = jk_force(MAX_V[i]);
        end
`endif
      end else begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          {j_d[i], k_d[i]} = ripple ? JK_TOGGLE : JK_HOLD;
          ripple = ripple & (up ? count[i] : ~count[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_d[g]),
      .k     (k_d[g]),
      .q     (count[g]),
      .qn    (count_n[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tc_q   <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      tc_q   <= tc_d;
      lerr_q <= lerr_d;
    end
  end

  assign tc       = tc_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_jk_counter.sv
// Scoreboard bench for jk_counter (WIDTH=4, MOD=10); honours JK_COUNTER_SAT_EN.
module tb_jk_counter;

  typedef struct packed {
    logic [3:0] cnt;
    logic       tc;
    logic       lerr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] load_val;
  logic [3:0] count, count_n;
  logic       tc, load_err;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  jk_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .count_n  (count_n),
    .tc       (tc),
    .load_err (load_err)
  );

  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [3:0] lv, input logic [3:0] ec, input logic et,
                      input logic el);
    exp_t x;
    @(negedge clk);
    rst_n    = r;
    load     = l;
    en       = e;
    up       = u;
    load_val = lv;
    x.cnt  = ec;
    x.tc   = et;
    x.lerr = el;
    sb.push_back(x);
  endtask

  // Monitor: every edge presents a new output word; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({count, tc, load_err} !== e) begin
          errors++;
          $display("FAIL out @%0t: got cnt=%0d tc=%0b lerr=%0b, exp cnt=%0d tc=%0b lerr=%0b",
                   $time, count, tc, load_err, e.cnt, e.tc, e.lerr);
        end
        checks++;
        if (count_n !== ~count) begin
          errors++;
          $display("FAIL count_n @%0t: got %b, exp %b", $time, count_n, ~count);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; load = 1'b1; en = 1'b1; up = 1'b1; load_val = 4'd5;

    // Reset dominates load and en.
    step(0, 1, 1, 1, 4'd5, 4'd0, 0, 0);
    step(0, 1, 1, 1, 4'd5, 4'd0, 0, 0);

    // Up count from 0 for 12 edges.
    for (int i = 1; i <= 12; i++) begin
`ifdef JK_COUNTER_SAT_EN
      step(1, 0, 1, 1, 4'd0, (i >= 9) ? 4'd9 : 4'(i), (i >= 10), 0);
`else
      step(1, 0, 1, 1, 4'd0, 4'(i % 10), (i == 10), 0);
`endif
    end

    // Load 3, count down 5, then reverse for one edge.
    step(1, 1, 0, 0, 4'd3, 4'd3, 0, 0);
    step(1, 0, 1, 0, 4'd0, 4'd2, 0, 0);
    step(1, 0, 1, 0, 4'd0, 4'd1, 0, 0);
    step(1, 0, 1, 0, 4'd0, 4'd0, 0, 0);
`ifdef JK_COUNTER_SAT_EN
    step(1, 0, 1, 0, 4'd0, 4'd0, 1, 0);
    step(1, 0, 1, 0, 4'd0, 4'd0, 1, 0);
    step(1, 0, 1, 1, 4'd0, 4'd1, 0, 0);
`else
    step(1, 0, 1, 0, 4'd0, 4'd9, 1, 0);
    step(1, 0, 1, 0, 4'd0, 4'd8, 0, 0);
    step(1, 0, 1, 1, 4'd0, 4'd9, 0, 0);
`endif

    // Load beats enable; out-of-range loads clamp to MOD-1 and flag once.
    step(1, 1, 1, 1, 4'd7,  4'd7, 0, 0);
    step(1, 1, 1, 1, 4'd12, 4'd9, 0, 1);
    step(1, 0, 0, 1, 4'd0,  4'd9, 0, 0);
    step(1, 1, 1, 0, 4'd15, 4'd9, 0, 1);
    step(1, 1, 0, 0, 4'd9,  4'd9, 0, 0);
    step(1, 0, 0, 0, 4'd0,  4'd9, 0, 0);

    // Mid-count reset beats load.
    step(1, 1, 0, 1, 4'd5, 4'd5, 0, 0);
    step(1, 0, 1, 1, 4'd0, 4'd6, 0, 0);
    step(0, 1, 1, 1, 4'd4, 4'd0, 0, 0);
    step(1, 0, 1, 1, 4'd0, 4'd1, 0, 0);
    step(1, 0, 1, 1, 4'd0, 4'd2, 0, 0);

    // Upper limit: wrap vs saturate.
    step(1, 1, 0, 1, 4'd8, 4'd8, 0, 0);
`ifdef JK_COUNTER_SAT_EN
    step(1, 0, 1, 1, 4'd0, 4'd9, 0, 0);
    step(1, 0, 1, 1, 4'd0, 4'd9, 1, 0);
    step(1, 0, 1, 1, 4'd0, 4'd9, 1, 0);
`else
    step(1, 0, 1, 1, 4'd0, 4'd9, 0, 0);
    step(1, 0, 1, 1, 4'd0, 4'd0, 1, 0);
    step(1, 0, 1, 1, 4'd0, 4'd1, 0, 0);
`endif

    // Hold drops tc.
    step(1, 0, 0, 1, 4'd0, 4'(count_hold_val()), 0, 0);

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never observed, exp 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic int count_hold_val();
`ifdef JK_COUNTER_SAT_EN
    return 9;
`else
    return 1;
`endif
  endfunction

endmodule
